bf_query_sched: RTL and testbench

- Sequences one bloom-filter membership query through the shared 9-stage pipelined 5-tuple hash unit.
- For each query it:
  - issues NUM_HASH seeded hash requests on consecutive cycles;
  - tracks them through the pipeline;
  - reads one bloom bit per returned hashkey;
  - AND-reduces the bits into a match flag.
- Sits between the packet-header parser (query side) and the packet-match decision logic (result side).
- Owns the hash unit's inputs and the bit-array read port.

---
 rtl/bf_pkg.sv | 22 ++
 rtl/bf_lat_tracker.sv | 26 ++
 rtl/bf_query_sched.sv | 158 +++++++++++++++
 tb/tb_bf_query_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants, FSM encoding and tuple type for the bloom-filter query scheduler.
package bf_pkg;

    localparam int unsigned HASH_LAT  = 9;
    localparam logic [31:0] DEF_SEED0 = 32'h9E3779B9;
    localparam logic [31:0] DEF_SEED1 = 32'h7F4A7C15;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESULT = 2'd3;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [31:0] ports;
        logic [7:0]  proto;
    } bf_tuple_t;

endpackage

// File: rtl/bf_lat_tracker.sv
// Fixed-depth single-bit shift register marking which hash-pipe slots carry a live request.
module bf_lat_tracker #(
    parameter int unsigned DEPTH = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/bf_query_sched.sv
// Bloom-filter query scheduler: issues NUM_HASH seeded hashes, reads one bit per key, ANDs them.
// Defining BF_QUERY_STATS_EN adds the stat_queries / stat_hits result counters.
module bf_query_sched
    import bf_pkg::*;
#(
    parameter int unsigned NUM_HASH = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] SEED0    = DEF_SEED0,
    parameter logic [31:0] SEED1    = DEF_SEED1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [31:0]       q_src_ip,
    input  logic [31:0]       q_dst_ip,
    input  logic [31:0]       q_ports,
    input  logic [7:0]        q_proto,
    output logic [31:0]       h_a0,
    output logic [31:0]       h_b0,
    output logic [31:0]       h_c0,
    output logic [31:0]       h_k0,
    output logic [31:0]       h_k1,
    output logic [7:0]        h_k2,
    input  logic [31:0]       h_hashkey,
    output logic              m_rd_en,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_match,
    output logic [4:0]        r_miss_cnt
`ifdef BF_QUERY_STATS_EN
    ,
    output logic [31:0]       stat_queries,
    output logic [31:0]       stat_hits
`endif
);

    localparam logic [4:0] LAST = 5'(NUM_HASH - 1);

    state_t     state;
    bf_tuple_t  tuple;
    logic [4:0] issue_cnt;
    logic [4:0] resp_cnt;
    logic       acc;
    logic       sample;
    logic       issuing;
    logic       trk_out;
    logic       unused_hash;

    // Gated with RST so q_ready is low while reset is held even though state reads IDLE.
    assign q_ready = (state == ST_IDLE) && !RST;
    assign r_valid = (state == ST_RESULT);
    assign issuing = (state == ST_ISSUE);

    assign h_a0 = tuple.src_ip;
    assign h_b0 = tuple.dst_ip;
    assign h_c0 = tuple.ports;
    assign h_k2 = tuple.proto;

    assign unused_hash = ^h_hashkey[31:ADDR_W];

    bf_lat_tracker #(
        .DEPTH (HASH_LAT)
    ) u_tracker (
        .clk  (CLK),
        .rst  (RST),
        .din  (issuing),
        .dout (trk_out)
    );

    // Read strobe one cycle after the key is valid; data sampled one cycle after the strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_rd_en   <= 1'b0;
            m_rd_addr <= '0;
            sample    <= 1'b0;
        end else begin
            m_rd_en <= trk_out;
            sample  <= m_rd_en;
            if (trk_out) begin
                m_rd_addr <= h_hashkey[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            tuple      <= '0;
            issue_cnt  <= '0;
            resp_cnt   <= '0;
            acc        <= 1'b0;
            r_match    <= 1'b0;
            r_miss_cnt <= '0;
            h_k0       <= '0;
            h_k1       <= '0;
        end else begin
            if (sample) begin
                acc        <= acc & m_rd_data;
                r_miss_cnt <= r_miss_cnt + 5'(!m_rd_data);
                resp_cnt   <= resp_cnt + 5'd1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (q_valid) begin
                        tuple      <= '{src_ip: q_src_ip, dst_ip: q_dst_ip,
                                        ports: q_ports, proto: q_proto};
                        acc        <= 1'b1;
                        issue_cnt  <= '0;
                        resp_cnt   <= '0;
                        r_miss_cnt <= '0;
                        h_k0       <= SEED0;
                        h_k1       <= SEED1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_cnt == LAST) begin
                        state <= ST_WAIT;
                    end else begin
                        issue_cnt <= issue_cnt + 5'd1;
                        h_k0      <= h_k0 + 32'd1;
                    end
                end
                ST_WAIT: begin
                    // Leave on the final sample so r_valid lands NUM_HASH+HASH_LAT+2 after issue.
                    if (sample && resp_cnt == LAST) begin
                        r_match <= acc & m_rd_data;
                        state   <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (r_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BF_QUERY_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_queries <= '0;
            stat_hits    <= '0;
        end else if (r_valid && r_ready) begin
            stat_queries <= stat_queries + 32'd1;
            if (r_match) begin
                stat_hits <= stat_hits + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bf_query_sched.sv
// Scoreboard bench for bf_query_sched with a behavioural hash pipe and bloom bit-array model.
module tb_bf_query_sched;

    localparam int          NH      = 4;
    localparam logic [31:0] SEED0_T = 32'hFFFFFFFE;
    localparam logic [31:0] SEED1_T = 32'h7F4A7C15;

    typedef struct {
        logic       match;
        logic [4:0] miss;
    } res_t;

    typedef struct {
        logic [31:0] a, b, c, k0;
        logic [7:0]  p;
    } iss_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [31:0] q_src_ip = '0, q_dst_ip = '0, q_ports = '0;
    logic [7:0]  q_proto = '0;
    logic [31:0] h_a0, h_b0, h_c0, h_k0, h_k1;
    logic [7:0]  h_k2;
    logic [31:0] h_hashkey;
    logic        m_rd_en;
    logic [11:0] m_rd_addr;
    logic        m_rd_data = 1'b0;
    logic        r_valid;
    logic        r_ready = 1'b1;
    logic        r_match;
    logic [4:0]  r_miss_cnt;
`ifdef BF_QUERY_STATS_EN
    logic [31:0] stat_queries, stat_hits;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rr_rand = 1'b0;

    logic        bloom [0:4095];
    logic [31:0] hpipe [0:8];

    res_t        res_q[$];
    iss_t        iss_q[$];
    logic [11:0] addr_q[$];

    bf_query_sched #(
        .NUM_HASH (NH),
        .ADDR_W   (12),
        .SEED0    (SEED0_T),
        .SEED1    (SEED1_T)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_src_ip   (q_src_ip),
        .q_dst_ip   (q_dst_ip),
        .q_ports    (q_ports),
        .q_proto    (q_proto),
        .h_a0       (h_a0),
        .h_b0       (h_b0),
        .h_c0       (h_c0),
        .h_k0       (h_k0),
        .h_k1       (h_k1),
        .h_k2       (h_k2),
        .h_hashkey  (h_hashkey),
        .m_rd_en    (m_rd_en),
        .m_rd_addr  (m_rd_addr),
        .m_rd_data  (m_rd_data),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_match    (r_match),
        .r_miss_cnt (r_miss_cnt)
`ifdef BF_QUERY_STATS_EN
        ,
        .stat_queries (stat_queries),
        .stat_hits    (stat_hits)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] hf(input logic [31:0] a, b, c, k0, k1, input logic [7:0] k2);
        logic [31:0] x;
        x = a ^ (b * 32'h85EBCA6B) ^ {c[15:0], c[31:16]} ^ (k0 * 32'hC2B2AE35) ^ k1 ^ {24'd0, k2};
        x = x ^ (x >> 15);
        x = x * 32'h2C1B3C6D;
        x = x ^ (x >> 12);
        return x;
    endfunction

    // External hash unit: key valid HASH_LAT (9) cycles after its inputs.
    always @(posedge CLK) begin
        hpipe[0] <= hf(h_a0, h_b0, h_c0, h_k0, h_k1, h_k2);
        for (int i = 1; i < 9; i++) hpipe[i] <= hpipe[i-1];
    end
    assign h_hashkey = hpipe[8];

    // Bit array: data one cycle after the strobe, junk otherwise.
    always @(posedge CLK) begin
        if (m_rd_en) m_rd_data <= bloom[m_rd_addr];
        else         m_rd_data <= 1'($urandom);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
    endtask

    task automatic push_model(input logic [31:0] s, d, p, input logic [7:0] pr);
        res_t        r;
        iss_t        it;
        logic [31:0] key;
        r.match = 1'b1;
        r.miss  = '0;
        for (int i = 0; i < NH; i++) begin
            it.a = s; it.b = d; it.c = p; it.p = pr;
            it.k0 = SEED0_T + 32'(i);
            iss_q.push_back(it);
            key = hf(s, d, p, it.k0, SEED1_T, pr);
            addr_q.push_back(key[11:0]);
            if (!bloom[key[11:0]]) begin
                r.match = 1'b0;
                r.miss  = r.miss + 5'd1;
            end
        end
        res_q.push_back(r);
    endtask

    task automatic send_query(input logic [31:0] s, d, p, input logic [7:0] pr,
                              output int acc_cyc);
        bit got = 1'b0;
        q_src_ip = s; q_dst_ip = d; q_ports = p; q_proto = pr;
        q_valid = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge CLK);
            if (q_ready) got = 1'b1;
        end
        if (!got) begin
            fail_now("query_accept");
            q_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        acc_cyc = cyc;
        push_model(s, d, p, pr);
        @(posedge CLK);
        #1;
        q_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge CLK);
            if (res_q.size() == 0 && !r_valid) done = 1'b1;
        end
        if (!done) fail_now("result_drain");
        @(posedge CLK);
        #1;
    endtask

    // Monitor / scoreboard
    int  issue_left = 0;
    int  hs_cyc = 0;
    int  rd_cnt = 0;
    int  rd_last = 0;
    bit  rv_prev = 1'b0;
    bit  qr_due = 1'b0;

    always @(negedge CLK) begin
        iss_t it;
        res_t e;
        if (RST) begin
            res_q.delete();
            iss_q.delete();
            addr_q.delete();
            issue_left = 0;
            rv_prev = 1'b0;
            qr_due = 1'b0;
        end else begin
            if (qr_due) begin
                chk("q_ready_after_result", 64'(q_ready), 64'd1);
                chk("r_valid_drop", 64'(r_valid), 64'd0);
                qr_due = 1'b0;
            end
            if (issue_left > 0) begin
                if (iss_q.size() == 0) fail_now("issue_expectation");
                else begin
                    it = iss_q.pop_front();
                    chk("h_k0", 64'(h_k0), 64'(it.k0));
                    chk("h_a0_b0", {h_a0, h_b0}, {it.a, it.b});
                    chk("h_c0_k2", {24'd0, h_c0, h_k2}, {24'd0, it.c, it.p});
                    chk("h_k1", 64'(h_k1), 64'(SEED1_T));
                end
                issue_left--;
            end
            if (q_valid && q_ready) begin
                issue_left = NH;
                hs_cyc = cyc;
                rd_cnt = 0;
            end
            if (m_rd_en) begin
                if (rd_cnt > 0) chk("rd_consecutive", 64'(cyc - rd_last), 64'd1);
                rd_cnt++;
                rd_last = cyc;
                if (addr_q.size() == 0) fail_now("unexpected_m_rd_en");
                else chk("m_rd_addr", 64'(m_rd_addr), 64'(addr_q.pop_front()));
            end
            if (r_valid) begin
                chk("q_ready_busy", 64'(q_ready), 64'd0);
                if (res_q.size() == 0) fail_now("unexpected_r_valid");
                else begin
                    e = res_q[0];
                    if (!rv_prev) begin
                        chk("latency", 64'(cyc - hs_cyc), 64'd16);
                        chk("rd_pulses", 64'(rd_cnt), 64'(NH));
                    end
                    chk("r_match", 64'(r_match), 64'(e.match));
                    chk("r_miss_cnt", 64'(r_miss_cnt), 64'(e.miss));
                    if (r_ready) begin
                        void'(res_q.pop_front());
                        qr_due = 1'b1;
                    end
                end
            end
            rv_prev = r_valid;
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (rr_rand) r_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int          acc_c [3];
        int          ac;
        bit          got;
        logic [31:0] key;

        for (int i = 0; i < 4096; i++) bloom[i] = 1'b1;
        for (int i = 0; i < 9; i++) hpipe[i] = '0;

        // Reset values while RST is held
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_q_ready", 64'(q_ready), 64'd0);
        chk("reset_ctl", {58'd0, r_valid, r_match, m_rd_en, 3'd0}, 64'd0);
        chk("reset_cnt_addr", {47'd0, r_miss_cnt, m_rd_addr}, 64'd0);
        chk("reset_h_k", {h_k0, h_k1}, 64'd0);
        chk("reset_h_tuple", {h_a0, h_b0}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("q_ready_after_reset", 64'(q_ready), 64'd1);
        @(posedge CLK);
        #1;

        // All bits set
        send_query(32'h0A000001, 32'hC0A80101, {16'd1234, 16'd80}, 8'd6, ac);
        wait_idle();

        // Clear the bit hash 2 of the next tuple lands on
        key = hf(32'h0A000002, 32'hC0A80102, {16'd5555, 16'd443}, SEED0_T + 32'd2, SEED1_T, 8'd17);
        bloom[key[11:0]] = 1'b0;
        send_query(32'h0A000002, 32'hC0A80102, {16'd5555, 16'd443}, 8'd17, ac);
        wait_idle();
        bloom[key[11:0]] = 1'b1;

        // Result held under back-pressure
        r_ready = 1'b0;
        send_query(32'h01020304, 32'h05060708, 32'h11112222, 8'd1, ac);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge CLK);
            if (r_valid) got = 1'b1;
        end
        if (!got) fail_now("stall_r_valid");
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #1;
        r_ready = 1'b1;
        wait_idle();

        // Back-to-back queries with q_valid held high
        for (int j = 0; j < 3; j++)
            send_query($urandom, $urandom, $urandom, 8'($urandom), acc_c[j]);
        chk("b2b_spacing_1", 64'(acc_c[1] - acc_c[0]), 64'd17);
        chk("b2b_spacing_2", 64'(acc_c[2] - acc_c[1]), 64'd17);
        wait_idle();

        // Reset in WAIT, three cycles after issue ends
        send_query(32'hDEADBEEF, 32'h12345678, 32'h0BAD0BAD, 8'd6, ac);
        repeat (7) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_ctl", {60'd0, q_ready, r_valid, m_rd_en, r_match}, 64'd0);
        chk("async_rst_h", {h_k0, h_a0}, 64'd0);
        chk("async_rst_cnt", {47'd0, r_miss_cnt, m_rd_addr}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge CLK);
            chk("quiet_after_rst", {62'd0, m_rd_en, r_valid}, 64'd0);
        end
        @(posedge CLK);
        #1;

        // Random queries over random bit arrays with random back-pressure
        rr_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 4096; i++) bloom[i] = ($urandom_range(0, 99) < 96);
            send_query($urandom, $urandom, $urandom, 8'($urandom), ac);
            wait_idle();
        end
        rr_rand = 1'b0;
        r_ready = 1'b1;
        repeat (3) @(posedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
